circuit2_hlsm: RTL and testbench

//  Multi-cycle, FSM-scheduled version of the circuit2 dataflow, with a start/done handshake.

---
 rtl/circuit2_hlsm_pkg.sv | 24 ++
 rtl/circuit2_hlsm_alu.sv | 36 +++
 rtl/circuit2_hlsm.sv | 120 ++++++++++++
 tb/tb_circuit2_hlsm.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/circuit2_hlsm_pkg.sv
// circuit2_hlsm_pkg
//   Shared definitions for the FSM-scheduled circuit2 datapath:
//   state codes (3-bit binary) and shared ALU operation codes.
package circuit2_hlsm_pkg;

   localparam int STATE_W = 3;

   // Code 7 is unused; the next-state logic sends it to ST_WAIT.
   typedef enum logic [STATE_W-1:0] {
      ST_WAIT  = 3'd0,
      ST_S1    = 3'd1,
      ST_S2    = 3'd2,
      ST_S3    = 3'd3,
      ST_S4    = 3'd4,
      ST_S5    = 3'd5,
      ST_FINAL = 3'd6
   } state_t;

   typedef enum logic {
      OP_ADD = 1'b0,
      OP_SUB = 1'b1
   } alu_op_t;

endpackage

// File: rtl/circuit2_hlsm_alu.sv
// circuit2_alu
//   Combinational shared arithmetic unit: one signed add/sub plus one
//   signed magnitude/equality comparator.
//   Ports:
//     a, b    in   add/sub operands (signed)
//     op      in   OP_ADD -> a+b, OP_SUB -> a-b (wraps modulo 2^DATAWIDTH)
//     cmp_a   in   comparator left operand (signed)
//     cmp_b   in   comparator right operand (signed)
//     y       out  add/sub result
//     lt      out  cmp_a < cmp_b, signed
//     eq      out  cmp_a == cmp_b
//   The comparator has its own operand pair so the schedule can compare
//   d/e in the same state that the add/sub unit produces f.
module circuit2_alu
   import circuit2_hlsm_pkg::*;
#(
   parameter int DATAWIDTH = 32
) (
   input  logic signed [DATAWIDTH-1:0] a,
   input  logic signed [DATAWIDTH-1:0] b,
   input  alu_op_t                     op,
   input  logic signed [DATAWIDTH-1:0] cmp_a,
   input  logic signed [DATAWIDTH-1:0] cmp_b,
   output logic signed [DATAWIDTH-1:0] y,
   output logic                        lt,
   output logic                        eq
);

   always_comb begin
      y = (op == OP_SUB) ? (a - b) : (a + b);
   end

   assign lt = (cmp_a < cmp_b);
   assign eq = (cmp_a == cmp_b);

endmodule

// File: rtl/circuit2_hlsm.sv
// circuit2_hlsm
//   Multi-cycle, FSM-scheduled circuit2 dataflow with a start/done handshake:
//     d=a+b, e=a+c, f=a-b, lt=(d<e), eq=(d==e),
//     g=lt?e:d, h=eq?f:g, x=g<<lt, z=h>>>eq
//   One shared add/sub unit and one comparator are reused across states.
//   Ports:
//     clk     in   rising-edge clock
//     rst     in   synchronous reset, active-low
//     start   in   request, only honoured in ST_WAIT
//     a,b,c   in   signed operands, captured on the accepting edge
//     busy    out  high in every state except ST_WAIT
//     done    out  one-cycle pulse while in ST_FINAL
//     x, z    out  registered results, updated only on leaving ST_S5
module circuit2_hlsm
   import circuit2_hlsm_pkg::*;
#(
   parameter int DATAWIDTH = 32
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start,
   input  logic signed [DATAWIDTH-1:0] a,
   input  logic signed [DATAWIDTH-1:0] b,
   input  logic signed [DATAWIDTH-1:0] c,
   output logic                        busy,
   output logic                        done,
   output logic signed [DATAWIDTH-1:0] x,
   output logic signed [DATAWIDTH-1:0] z
);

   state_t state, state_nxt;

   logic signed [DATAWIDTH-1:0] ra, rb, rc;
   logic signed [DATAWIDTH-1:0] d, e, f, g, h;
   logic                        lt, eq;

   alu_op_t                     alu_op;
   logic signed [DATAWIDTH-1:0] alu_a, alu_b, alu_y;
   logic                        alu_lt, alu_eq;

   circuit2_alu #(.DATAWIDTH(DATAWIDTH)) u_alu (
      .a     (alu_a),
      .b     (alu_b),
      .op    (alu_op),
      .cmp_a (d),
      .cmp_b (e),
      .y     (alu_y),
      .lt    (alu_lt),
      .eq    (alu_eq)
   );

   // state register
   always_ff @(posedge clk) begin
      if (!rst) state <= ST_WAIT;
      else      state <= state_nxt;
   end

   // next-state logic
   always_comb begin
      state_nxt = ST_WAIT;
      case (state)
         ST_WAIT:  state_nxt = start ? ST_S1 : ST_WAIT;
         ST_S1:    state_nxt = ST_S2;
         ST_S2:    state_nxt = ST_S3;
         ST_S3:    state_nxt = ST_S4;
         ST_S4:    state_nxt = ST_S5;
         ST_S5:    state_nxt = ST_FINAL;
         ST_FINAL: state_nxt = ST_WAIT;
         default:  state_nxt = ST_WAIT;
      endcase
   end

   // outputs and shared-unit operand steering
   always_comb begin
      busy   = (state != ST_WAIT);
      done   = (state == ST_FINAL);
      alu_op = OP_ADD;
      alu_a  = ra;
      alu_b  = rb;
      case (state)
         ST_S2:   alu_b  = rc;      // e = a + c
         ST_S3:   alu_op = OP_SUB;  // f = a - b
         default: ;                 // d = a + b (S1), idle otherwise
      endcase
   end

   // datapath registers; each intermediate is written in exactly one state
   always_ff @(posedge clk) begin
      if (!rst) begin
         ra <= '0; rb <= '0; rc <= '0;
         d  <= '0; e  <= '0; f  <= '0;
         g  <= '0; h  <= '0;
         lt <= 1'b0; eq <= 1'b0;
         x  <= '0; z  <= '0;
      end else begin
         case (state)
            ST_WAIT: if (start) begin
               ra <= a; rb <= b; rc <= c;
            end
            ST_S1: d <= alu_y;
            ST_S2: e <= alu_y;
            ST_S3: begin
               f  <= alu_y;
               lt <= alu_lt;
               eq <= alu_eq;
            end
            ST_S4: begin
               g <= lt ? e : d;
               h <= eq ? f : (lt ? e : d);
            end
            ST_S5: begin
               x <= g <<< lt;
               z <= h >>> eq;   // sign-filling
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_circuit2_hlsm.sv
module tb_circuit2_hlsm;

   logic               clk = 1'b0;
   logic               rst = 1'b0;
   logic               start = 1'b0;
   logic signed [31:0] a = '0, b = '0, c = '0;
   logic               busy, done;
   logic signed [31:0] x, z;

   int n_vec = 0;
   int n_err = 0;

   circuit2_hlsm #(.DATAWIDTH(32)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .c     (c),
      .busy  (busy),
      .done  (done),
      .x     (x),
      .z     (z)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)",
                  tag, $signed(obs), obs, $signed(exp), exp);
      end
   endtask

   // Reference: straight from the dataflow equations, with doubling and
   // floor-halving in place of the shifts.
   function automatic void model(input int ia, ib, ic, output int ox, oz);
      int d, e, f, g, h;
      bit lt, eq;
      d  = ia + ib;
      e  = ia + ic;
      f  = ia - ib;
      lt = (d < e);
      eq = (d == e);
      g  = lt ? e : d;
      h  = eq ? f : g;
      ox = lt ? g * 2 : g;
      oz = eq ? (h - (h & 1)) / 2 : h;
   endfunction

   // Issue one op from WAIT, then sample each cycle until done (bounded).
   task automatic do_op(input int ia, ib, ic, output int ox, oz, lat, bcnt);
      @(negedge clk);
      a = ia; b = ib; c = ic; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      a = $urandom; b = $urandom; c = $urandom;
      lat = 0; bcnt = 0; ox = 0; oz = 0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (busy) bcnt++;
         if (done) begin
            lat = i; ox = x; oz = z;
            break;
         end
      end
   endtask

   task automatic run_and_check(input string tag, input int ia, ib, ic, ex, ez);
      int ox, oz, lat, bcnt;
      do_op(ia, ib, ic, ox, oz, lat, bcnt);
      chk({tag, " latency"}, lat, 6);
      chk({tag, " busy cycles"}, bcnt, 6);
      chk({tag, " x"}, ox, ex);
      chk({tag, " z"}, oz, ez);
      @(negedge clk);
      chk({tag, " done width"}, {31'b0, done}, 0);
      chk({tag, " idle busy"}, {31'b0, busy}, 0);
   endtask

   initial begin
      int ex, ez, ndone, fx, fz, didx0, didx1, didx2;
      int ra, rb, rc;

      // reset
      rst = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset busy", {31'b0, busy}, 0);
      chk("reset done", {31'b0, done}, 0);
      chk("reset x", x, 0);
      chk("reset z", z, 0);
      rst = 1'b1;

      // directed cases
      run_and_check("dir1", 5, 3, 1, 8, 8);
      run_and_check("dir2", 1, 2, 5, 12, 6);
      run_and_check("dir3", 0, 5, 5, 5, -3);
      run_and_check("dir4", 4, 2, 2, 6, 1);
      run_and_check("dir5", -8, -2, 0, -16, -8);
      model(32'h7FFF_FFFF, 1, 0, ex, ez);
      run_and_check("wrap", 32'h7FFF_FFFF, 1, 0, ex, ez);
      chk("wrap x const", ex, 32'hFFFF_FFFE);

      // start pulsed during S2 must be ignored
      @(negedge clk);
      a = -8; b = -2; c = 0; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      ndone = 0; fx = 0; fz = 0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (i == 2) begin start = 1'b1; a = 5; b = 3; c = 1; end
         if (i == 3) start = 1'b0;
         if (done) begin
            if (ndone == 0) begin fx = x; fz = z; end
            ndone++;
         end
      end
      chk("ign done count", ndone, 1);
      chk("ign x", fx, -16);
      chk("ign z", fz, -8);

      // reset in S3 abandons the op
      @(negedge clk);
      a = 1; b = 2; c = 5; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      @(negedge clk); @(negedge clk); @(negedge clk);   // now in S3
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      chk("abort busy", {31'b0, busy}, 0);
      chk("abort x", x, 0);
      chk("abort z", z, 0);
      ndone = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (done) ndone++;
      end
      chk("abort no done", ndone, 0);
      run_and_check("post abort", 5, 3, 1, 8, 8);

      // start held high: back-to-back ops every 7 cycles
      @(negedge clk);
      a = 5; b = 3; c = 1; start = 1'b1;
      @(posedge clk); #1;
      a = 1; b = 2; c = 5;
      ndone = 0; didx0 = 0; didx1 = 0; didx2 = 0;
      for (int i = 1; i <= 26; i++) begin
         @(negedge clk);
         if (i == 19) start = 1'b0;
         if (done) begin
            if (ndone == 0) begin
               didx0 = i;
               chk("b2b x1", x, 8);
               chk("b2b z1", z, 8);
            end else if (ndone == 1) begin
               didx1 = i;
               chk("b2b x2", x, 12);
               chk("b2b z2", z, 6);
            end else didx2 = i;
            ndone++;
         end
         if (i >= 7 && i <= 12) begin
            chk("b2b x hold", x, 8);
            chk("b2b z hold", z, 8);
         end
      end
      chk("b2b done count", ndone, 3);
      chk("b2b done1 idx", didx0, 6);
      chk("b2b done2 idx", didx1, 13);
      chk("b2b done3 idx", didx2, 20);

      // randomized ops vs reference model
      for (int k = 0; k < 40; k++) begin
         ra = $urandom; rb = $urandom; rc = $urandom;
         case (k % 4)
            0: rc = rb;                                    // forces eq
            1: begin ra = $urandom_range(0, 40) - 20; rb = $urandom_range(0, 40) - 20;
                     rc = $urandom_range(0, 40) - 20; end
            default: ;
         endcase
         model(ra, rb, rc, ex, ez);
         run_and_check($sformatf("rnd%0d", k), ra, rb, rc, ex, ez);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
